// File: rtl/ram_pkg.sv
// Shared constants for the dual-port synchronous RAM: read-during-write
// mode encodings and the clear-sequencer state encoding.
package ram_pkg;

    // Same-address read-during-write behaviour selector values
    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Clear sequencer states
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

endpackage

// File: rtl/ram_be_merge.sv
// Byte-enable merge: each byte of the result comes from new_word when its
// enable bit is set, otherwise from old_word.
module ram_be_merge #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   merged
);

    // Select each byte independently from the old or the new word
    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_dualport_synch.sv
// Simple dual-port synchronous RAM: one write port with byte enables, one
// read port, optional output register, configurable read-during-write
// result and an optional post-reset zero-fill sequence.
module ram_dualport_synch
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   d,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    output logic                    init_busy
);

    localparam int unsigned         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_bypass;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_v;

    assign init_busy = (state == CLEAR);
    assign wr_acc    = we & ~init_busy;
    assign rd_acc    = re & ~init_busy;

    // Single merge instance serves both the write path and the new-data
    // bypass: the bypass only applies when raddr == waddr, so the old word
    // fed to the merge is the same word the read would have returned.
    ram_be_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_word (mem[waddr]),
        .new_word (d),
        .be       (be),
        .merged   (wr_merged)
    );

    assign rd_bypass = (RDW_MODE == RDW_NEW) && wr_acc && (waddr == raddr);

    // Memory write port is shared between the clear sequencer and user writes
    always_comb begin
        mem_we    = wr_acc;
        mem_waddr = waddr;
        mem_wdata = wr_merged;
        if (init_busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt[ADDR_WIDTH-1:0];
            mem_wdata = '0;
        end
    end

    // Clear sequencer: zero-fill every address once after reset, then idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
                state <= READY;
            end
        end
    end

    // Memory array without reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read stage: capture the addressed word, hold it between accepted reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            rd_v <= rd_acc;
            if (rd_acc) begin
                rd_q <= rd_bypass ? wr_merged : mem[raddr];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;
        logic                  out_v;

        // Optional output pipeline stage, holding data between valid reads
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
                out_v <= 1'b0;
            end else begin
                out_v <= rd_v;
                if (rd_v) begin
                    out_q <= rd_q;
                end
            end
        end

        assign q       = out_q;
        assign q_valid = out_v;
    end else begin : g_no_out_reg
        assign q       = rd_q;
        assign q_valid = rd_v;
    end

endmodule

// File: doc/ram_dualport_synch.md
RAM_DUALPORT_SYNCH -- requirements
Module: ram_dualport_synch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10: address width; depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter RDW_MODE, default 0: same-address read-during-write result; 0 returns old data, 1 returns new data.
REQ-004 The block SHALL have parameter OUT_REG, default 0: 1 adds one output pipeline register.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1: 1 zero-fills the memory after reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port we, input, 1 bit: write request.
REQ-009 The block SHALL have port be, input, DATA_WIDTH/8 bits: byte enables for the write; bit i covers d[8i+7:8i].
REQ-010 The block SHALL have port waddr, input, ADDR_WIDTH bits: write address.
REQ-011 The block SHALL have port d, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port re, input, 1 bit: read request.
REQ-013 The block SHALL have port raddr, input, ADDR_WIDTH bits: read address.
REQ-014 The block SHALL have port q, output, DATA_WIDTH bits: read data.
REQ-015 The block SHALL have port q_valid, output, 1 bit: q holds the data of an accepted read.
REQ-016 The block SHALL have port init_busy, output, 1 bit: clear sequence in progress; requests are ignored.

Function
REQ-017 A write with we=1 and init_busy=0 SHALL update only the bytes of mem[waddr] whose be bit is 1, at the clock edge.
REQ-018 A write with be all-zero SHALL leave memory unchanged.
REQ-019 A read with re=1 and init_busy=0 SHALL present mem[raddr] on q with q_valid=1 after 1+OUT_REG cycles.
REQ-020 q SHALL hold its last value while q_valid=0; q_valid SHALL be 1 only for accepted reads, one cycle per read.
REQ-021 The block SHALL accept back-to-back reads every cycle, fully pipelined.
REQ-022 When the read and write are accepted in the same cycle with raddr==waddr, RDW_MODE=0 SHALL return the pre-write word.
REQ-023 In the same case, RDW_MODE=1 SHALL return the byte-merged post-write word: enabled bytes from d, other bytes old.
REQ-024 Reads and writes to different addresses in the same cycle SHALL not interact.
REQ-025 The clear FSM SHALL have states CLEAR and READY.
REQ-026 On reset release with CLEAR_ON_RESET=1, the FSM SHALL enter CLEAR and write zero to addresses 0 through 2**ADDR_WIDTH-1, one per cycle, in ascending order.
REQ-027 After address 2**ADDR_WIDTH-1 the FSM SHALL move to READY.
REQ-028 init_busy SHALL be 1 exactly during CLEAR, i.e. for 2**ADDR_WIDTH cycles.
REQ-029 we and re SHALL be ignored while init_busy=1, and no q_valid SHALL result from them.
REQ-030 With CLEAR_ON_RESET=0 the FSM SHALL start in READY, init_busy SHALL stay 0, and memory contents SHALL be undefined until written.
REQ-031 The clear address counter SHALL be ADDR_WIDTH+1 bits wide so the terminal count does not wrap.

Reset
REQ-032 Asserting rst_n=0 SHALL asynchronously set q=0, q_valid=0, all pipeline valid bits to 0, the clear counter to 0, and the FSM to CLEAR (or READY if CLEAR_ON_RESET=0).
REQ-033 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-034 Reset SHALL not directly clear the memory array; contents are cleared only by the clear sequence.

Structure
REQ-035 A shared package ram_pkg SHALL hold the RDW_MODE encodings RDW_OLD=0 and RDW_NEW=1 and the FSM state encoding.
REQ-036 Byte-enable merge logic SHALL be a sub-module ram_be_merge, combinational, (old, new, be) -> merged, reused for the write and the RDW_MODE=1 bypass.
REQ-037 The memory array SHALL have no reset so it infers block RAM.

Verification
REQ-038 Reset release, DATA_WIDTH=8, ADDR_WIDTH=4 -> init_busy=1 for exactly 16 cycles; afterwards a read of every address returns 0x00.
REQ-039 Write 0xA5B6 with be=2'b01 to addr 3 (DATA_WIDTH=16) over existing 0x1122 -> a read of addr 3 returns 0x11B6.
REQ-040 Same-cycle write 0xFF and read of addr 5 holding 0x12 -> q=0x12 for RDW_MODE=0 and q=0xFF for RDW_MODE=1.
REQ-041 OUT_REG=1 with reads of addrs 0,1,2 on consecutive cycles -> q_valid high for 3 consecutive cycles starting 2 cycles after the first read, with data in order.
REQ-042 rst_n pulsed low at clear address 7 -> q_valid=0 and q=0 immediately; init_busy stays 1 for a full 2**ADDR_WIDTH cycles after release.
REQ-043 we=1 and re=1 during CLEAR -> no q_valid and no memory change; the write's data is absent when read after READY.
